// File: rtl/cu_microsequencer.sv
// Next-state engine for the microprogrammed control unit: owns the microstore
// address register, the subroutine return stack, the memory-wait counter and sticky error flags.
module cu_microsequencer #(
    parameter int STATE_W     = 7,
    parameter int STACK_DEPTH = 4,
    parameter int RESET_STATE = 0,
    parameter int FETCH_STATE = 1,
    parameter int ERR_STATE   = 127,
    parameter int MOC_TIMEOUT = 15
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         stall,
    input  logic [2:0]                   next_sel,
    input  logic [STATE_W-1:0]           cr_addr,
    input  logic                         cond,
    input  logic                         cond_inv,
    input  logic [STATE_W-1:0]           decode_state,
    input  logic                         moc,
    input  logic                         clr_err,
    output logic [STATE_W-1:0]           state,
    output logic                         mem_wait,
    output logic [$clog2(STACK_DEPTH):0] sp,
    output logic                         err_ovf,
    output logic                         err_unf,
    output logic                         err_to
);

    localparam int SP_W  = $clog2(STACK_DEPTH) + 1;
    localparam int IDX_W = SP_W - 1;
    localparam int CNT_W = $clog2(MOC_TIMEOUT + 1);

    localparam logic [2:0] SEQ_INC    = 3'b000;
    localparam logic [2:0] SEQ_JUMP   = 3'b001;
    localparam logic [2:0] SEQ_DECODE = 3'b010;
    localparam logic [2:0] SEQ_CJMP   = 3'b011;
    localparam logic [2:0] SEQ_WAIT   = 3'b100;
    localparam logic [2:0] SEQ_RET    = 3'b101;
    localparam logic [2:0] SEQ_CALL   = 3'b110;
    localparam logic [2:0] SEQ_FETCH  = 3'b111;

    localparam logic [STATE_W-1:0] RESET_S = STATE_W'(RESET_STATE);
    localparam logic [STATE_W-1:0] FETCH_S = STATE_W'(FETCH_STATE);
    localparam logic [STATE_W-1:0] ERR_S   = STATE_W'(ERR_STATE);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(MOC_TIMEOUT - 1);
    localparam logic [SP_W-1:0]    SP_FULL  = SP_W'(STACK_DEPTH);

    logic [STATE_W-1:0] state_q, state_d;
    logic [SP_W-1:0]    sp_q, sp_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               err_ovf_q, err_ovf_d;
    logic               err_unf_q, err_unf_d;
    logic               err_to_q, err_to_d;
    logic [STATE_W-1:0] stack_q [STACK_DEPTH];

    logic [STATE_W-1:0] inc_addr;
    logic [SP_W-1:0]    sp_dec;
    logic               take_branch;
    logic               push_en;
    logic               set_ovf, set_unf, set_to;

    assign inc_addr    = state_q + STATE_W'(1);
    assign sp_dec      = sp_q - SP_W'(1);
    assign take_branch = cond ^ cond_inv;

    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        push_en = 1'b0;
        set_ovf = 1'b0;
        set_unf = 1'b0;
        set_to  = 1'b0;

        if (!stall) begin
            if (next_sel != SEQ_WAIT) begin
                cnt_d = '0;
            end
            case (next_sel)
                SEQ_INC:    state_d = inc_addr;
                SEQ_JUMP:   state_d = cr_addr;
                SEQ_DECODE: state_d = decode_state;
                SEQ_CJMP:   state_d = take_branch ? cr_addr : inc_addr;
                SEQ_WAIT: begin
                    if (moc) begin
                        state_d = inc_addr;
                        cnt_d   = '0;
                    end else if (cnt_q < CNT_LAST) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end else begin
                        state_d = ERR_S;
                        set_to  = 1'b1;
                        cnt_d   = '0;
                    end
                end
                SEQ_RET: begin
                    if (sp_q != '0) begin
                        state_d = stack_q[sp_dec[IDX_W-1:0]];
                        sp_d    = sp_dec;
                    end else begin
                        state_d = ERR_S;
                        set_unf = 1'b1;
                    end
                end
                SEQ_CALL: begin
                    if (sp_q < SP_FULL) begin
                        push_en = 1'b1;
                        sp_d    = sp_q + SP_W'(1);
                        state_d = cr_addr;
                    end else begin
                        state_d = ERR_S;
                        set_ovf = 1'b1;
                    end
                end
                SEQ_FETCH:  state_d = FETCH_S;
                default:    state_d = inc_addr;
            endcase
        end

        // A new error in the same cycle as clr_err leaves the flag set.
        err_ovf_d = (err_ovf_q & ~clr_err) | set_ovf;
        err_unf_d = (err_unf_q & ~clr_err) | set_unf;
        err_to_d  = (err_to_q  & ~clr_err) | set_to;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= RESET_S;
            sp_q      <= '0;
            cnt_q     <= '0;
            err_ovf_q <= 1'b0;
            err_unf_q <= 1'b0;
            err_to_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            sp_q      <= sp_d;
            cnt_q     <= cnt_d;
            err_ovf_q <= err_ovf_d;
            err_unf_q <= err_unf_d;
            err_to_q  <= err_to_d;
        end
    end

    // Stack storage needs no reset: clearing sp makes every entry unreachable.
    always_ff @(posedge clk) begin
        if (!reset && push_en) begin
            stack_q[sp_q[IDX_W-1:0]] <= inc_addr;
        end
    end

    assign state    = state_q;
    assign sp       = sp_q;
    assign err_ovf  = err_ovf_q;
    assign err_unf  = err_unf_q;
    assign err_to   = err_to_q;
    assign mem_wait = (next_sel == SEQ_WAIT) && !moc && !reset;

endmodule

// File: tb/tb_cu_microsequencer.sv
// Scoreboard bench for cu_microsequencer: directed scenarios plus random
// sequencing, checked against a queue-based behavioural model.
module tb_cu_microsequencer;

    localparam int SW   = 7;
    localparam int DEP  = 4;
    localparam int ERRS = 127;
    localparam int TO   = 15;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         stall = 1'b0;
    logic [2:0]   next_sel = 3'b000;
    logic [SW-1:0] cr_addr = '0;
    logic         cond = 1'b0;
    logic         cond_inv = 1'b0;
    logic [SW-1:0] decode_state = '0;
    logic         moc = 1'b0;
    logic         clr_err = 1'b0;
    logic [SW-1:0] state;
    logic         mem_wait;
    logic [2:0]   sp;
    logic         err_ovf, err_unf, err_to;

    cu_microsequencer #(
        .STATE_W(SW), .STACK_DEPTH(DEP), .RESET_STATE(0), .FETCH_STATE(1),
        .ERR_STATE(ERRS), .MOC_TIMEOUT(TO)
    ) dut (
        .clk(clk), .reset(reset), .stall(stall), .next_sel(next_sel),
        .cr_addr(cr_addr), .cond(cond), .cond_inv(cond_inv),
        .decode_state(decode_state), .moc(moc), .clr_err(clr_err),
        .state(state), .mem_wait(mem_wait), .sp(sp),
        .err_ovf(err_ovf), .err_unf(err_unf), .err_to(err_to)
    );

    always #5 clk = ~clk;

    typedef struct {
        int st;
        int spv;
        int err;   // {ovf, unf, to}
        int mw;
        int dst;   // independently stated expected state, -1 = none
        int dsp;   // independently stated expected sp, -1 = none
    } exp_t;

    exp_t exp_q[$];
    int   total = 0;
    int   passed = 0;

    // Behavioural model state
    int m_state = 0;
    int m_stack[$];
    int m_wait = 0;
    bit m_ovf = 0, m_unf = 0, m_to = 0;

    function automatic void chk(string name, logic [31:0] act, int expv);
        total++;
        if (act === 32'(expv)) passed++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, expv, $time);
    endfunction

    task automatic model(input bit r, input bit stl, input int sel, input int addr,
                         input bit c, input bit ci, input int dec, input bit mo,
                         input bit clr, output exp_t e);
        int nxt;
        bit n_ovf, n_unf, n_to;
        n_ovf = 0; n_unf = 0; n_to = 0;
        nxt = (m_state + 1) % (1 << SW);
        e.mw = (sel == 4 && !mo && !r) ? 1 : 0;
        if (r) begin
            m_state = 0;
            m_stack.delete();
            m_wait = 0;
            m_ovf = 0; m_unf = 0; m_to = 0;
        end else if (stl) begin
            if (clr) begin m_ovf = 0; m_unf = 0; m_to = 0; end
        end else begin
            if (sel != 4) m_wait = 0;
            case (sel)
                1: m_state = addr;
                2: m_state = dec;
                3: m_state = (c != ci) ? addr : nxt;
                4: begin
                    if (mo) begin m_state = nxt; m_wait = 0; end
                    else if (m_wait + 1 < TO) m_wait++;
                    else begin m_state = ERRS; n_to = 1; m_wait = 0; end
                end
                5: begin
                    if (m_stack.size() > 0) m_state = m_stack.pop_back();
                    else begin m_state = ERRS; n_unf = 1; end
                end
                6: begin
                    if (m_stack.size() < DEP) begin m_stack.push_back(nxt); m_state = addr; end
                    else begin m_state = ERRS; n_ovf = 1; end
                end
                7: m_state = 1;
                default: m_state = nxt;
            endcase
            if (clr) begin m_ovf = 0; m_unf = 0; m_to = 0; end
            m_ovf |= n_ovf; m_unf |= n_unf; m_to |= n_to;
        end
        e.st  = m_state;
        e.spv = m_stack.size();
        e.err = {29'd0, m_ovf, m_unf, m_to};
    endtask

    task automatic cyc(input bit r, input bit stl, input int sel, input int addr,
                       input bit c, input bit ci, input int dec, input bit mo,
                       input bit clr, input int dst, input int dsp);
        exp_t e;
        @(negedge clk);
        reset = r; stall = stl; next_sel = 3'(sel); cr_addr = SW'(addr);
        cond = c; cond_inv = ci; decode_state = SW'(dec); moc = mo; clr_err = clr;
        model(r, stl, sel, addr, c, ci, dec, mo, clr, e);
        e.dst = dst;
        e.dsp = dsp;
        exp_q.push_back(e);
    endtask

    task automatic sq(input int sel, input int addr, input int dst, input int dsp);
        cyc(0, 0, sel, addr, 0, 0, 0, 0, 0, dst, dsp);
    endtask

    task automatic wt(input bit stl, input bit mo, input int dst);
        cyc(0, stl, 4, 0, 0, 0, 0, mo, 0, dst, -1);
    endtask

    // Monitor: one registered result per clock, sampled just after the edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("state", 32'(state), e.st);
                chk("sp", 32'(sp), e.spv);
                chk("err_flags", {29'd0, err_ovf, err_unf, err_to}, e.err);
                chk("mem_wait", 32'(mem_wait), e.mw);
                if (e.dst >= 0) chk("state_directed", 32'(state), e.dst);
                if (e.dsp >= 0) chk("sp_directed", 32'(sp), e.dsp);
            end
        end
    end

    initial begin
        // Reset, increment, jump and wrap
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sq(0, 0, 1, 0); sq(0, 0, 2, 0); sq(0, 0, 3, 0);
        sq(1, 126, 126, 0); sq(0, 0, 127, 0); sq(0, 0, 0, 0);
        sq(2, 0, -1, -1);
        cyc(0, 0, 2, 0, 0, 0, 77, 0, 0, 77, 0);
        sq(7, 0, 1, 0);
        // Conditional branch
        cyc(0, 0, 3, 40, 1, 0, 0, 0, 0, 40, 0);
        cyc(0, 0, 3, 40, 1, 1, 0, 0, 0, 41, 0);
        // Memory wait then completion, then timeout
        sq(1, 10, 10, 0);
        wt(0, 0, 10); wt(0, 0, 10); wt(0, 0, 10); wt(0, 1, 11);
        for (int i = 0; i < TO; i++) wt(0, 0, (i == TO - 1) ? ERRS : 11);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Nested call/return
        sq(1, 5, 5, 0);
        sq(6, 20, 20, 1); sq(6, 30, 30, 2); sq(5, 0, 21, 1); sq(5, 0, 6, 0);
        // Overflow, underflow, clear
        for (int i = 0; i < 5; i++) sq(6, 50, (i == 4) ? ERRS : 50, (i == 4) ? 4 : i + 1);
        for (int i = 0; i < 5; i++) sq(5, 0, (i == 4) ? ERRS : ((i == 3) ? 7 : 51), (i == 4) ? 0 : 3 - i);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Stall freezes the wait counter; the timeout still needs 15 active waits
        sq(1, 10, 10, 0);
        wt(0, 0, 10); wt(1, 0, 10); wt(1, 0, 10);
        for (int i = 0; i < TO - 1; i++) wt(0, 0, (i == TO - 2) ? ERRS : 10);
        cyc(0, 1, 0, 0, 0, 0, 0, 0, 1, ERRS, 0);
        // Reset mid-wait with two stacked returns
        sq(1, 3, 3, 0); sq(6, 20, 20, 1); sq(6, 30, 30, 2);
        wt(0, 0, 30); wt(0, 0, 30);
        cyc(1, 0, 4, 0, 0, 0, 0, 0, 0, 0, 0);
        sq(0, 0, 1, 0);
        sq(5, 0, ERRS, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        // Random sequencing
        for (int i = 0; i < 600; i++) begin
            cyc(($urandom_range(0, 63) == 0), ($urandom_range(0, 7) == 0),
                $urandom_range(0, 7), $urandom_range(0, 127),
                $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 127),
                ($urandom_range(0, 3) == 0), ($urandom_range(0, 15) == 0), -1, -1);
        end
        repeat (3) @(negedge clk);
        total++;
        if (exp_q.size() == 0) passed++;
        else $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
